// File: rtl/mnacidpro_seq.sv
// mnacidpro_seq: sequencer for the nucleic-acid purification fluidics.
// Each start runs one sample through LYSIS -> WASH -> ELUTE. Every stage is
// followed by an all-closed SETTLE window (break-before-make). Each eluate is
// routed to the next collect outlet, and outlet occupancy is tracked.
// Valve convention: 1 = pressurised/closed, 0 = open.
module mnacidpro_seq #(
    parameter int SIZE        = 6,
    parameter int PUMP_PHASES = 3,
    parameter int CNT_W       = 16,
    parameter int SETTLE_CYC  = 2,
    localparam int SLOT_W     = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   clear_slots,
    input  logic [CNT_W-1:0]       phase_div,
    input  logic [CNT_W-1:0]       lysis_strokes,
    input  logic [CNT_W-1:0]       wash_strokes,
    input  logic [CNT_W-1:0]       elute_strokes,
    output logic                   lysis_ctrl,
    output logic                   wash_ctrl,
    output logic                   elute_ctrl,
    output logic                   waste_ctrl,
    output logic                   bead_trap_ctrl,
    output logic                   collect_ctrl,
    output logic [PUMP_PHASES-1:0] pump,
    output logic [SIZE-1:0]        collect_sel,
    output logic [SLOT_W-1:0]      slot,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic                   full
);

    localparam int K_W  = $clog2(PUMP_PHASES);
    localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LYSIS  = 3'd1;
    localparam logic [2:0] ST_WASH   = 3'd2;
    localparam logic [2:0] ST_ELUTE  = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;

    // Stage tag: which stage the current SETTLE window follows.
    localparam logic [1:0] TAG_LYSIS = 2'd0;
    localparam logic [1:0] TAG_WASH  = 2'd1;
    localparam logic [1:0] TAG_ELUTE = 2'd2;
    localparam logic [1:0] TAG_ABORT = 2'd3;

    // Valve vector order: {lysis, wash, elute, waste, bead_trap, collect}.
    localparam logic [5:0] VALVES_CLOSED = 6'b111111;
    localparam logic [5:0] VALVES_LYSIS  = 6'b011011;
    localparam logic [5:0] VALVES_WASH   = 6'b101011;
    localparam logic [5:0] VALVES_ELUTE  = 6'b110100;

    logic [2:0]             state_r, state_s;
    logic [1:0]             tag_r, tag_s;
    logic [CNT_W-1:0]       phase_r, phase_s;
    logic [K_W-1:0]         k_r, k_s;
    logic [CNT_W-1:0]       stroke_r, stroke_s;
    logic [ST_W-1:0]        settle_r, settle_s;
    logic [SLOT_W-1:0]      slot_r, slot_s;
    logic                   full_r, full_s;
    logic                   done_s, aborted_s, load_s;
    logic [CNT_W-1:0]       div_r, lys_r, wsh_r, elu_r;
    logic [CNT_W-1:0]       cur_strokes_s;
    logic                   phase_last_s, stage_last_s;
    logic [5:0]             valves_r, valves_s;
    logic [PUMP_PHASES-1:0] pump_r, pump_s;
    logic [SIZE-1:0]        sel_r, sel_s;
    logic                   busy_r, done_r, aborted_r;

    // A stage with zero strokes is skipped straight into its SETTLE window.
    function automatic logic [2:0] entry_state(input logic [1:0] tag, input logic [CNT_W-1:0] strokes);
        logic [2:0] st;
        if (strokes == {CNT_W{1'b0}}) begin
            st = ST_SETTLE;
        end else begin
            case (tag)
                TAG_LYSIS: st = ST_LYSIS;
                TAG_WASH:  st = ST_WASH;
                TAG_ELUTE: st = ST_ELUTE;
                default:   st = ST_SETTLE;
            endcase
        end
        return st;
    endfunction

    // All pump valves closed except the one for the active phase.
    function automatic logic [PUMP_PHASES-1:0] pump_pattern(input logic [K_W-1:0] k);
        return ~({{(PUMP_PHASES-1){1'b0}}, 1'b1} << k);
    endfunction

    function automatic logic [SIZE-1:0] one_hot(input logic [SLOT_W-1:0] idx);
        return {{(SIZE-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Stroke budget of the stage currently running, and end-of-stage detection.
    always_comb begin
        case (state_r)
            ST_LYSIS: cur_strokes_s = lys_r;
            ST_WASH:  cur_strokes_s = wsh_r;
            ST_ELUTE: cur_strokes_s = elu_r;
            default:  cur_strokes_s = {CNT_W{1'b0}};
        endcase
        phase_last_s = (phase_r == div_r - CNT_W'(1));
        stage_last_s = phase_last_s && (k_r == K_W'(PUMP_PHASES - 1))
                       && (stroke_r == cur_strokes_s - CNT_W'(1));
    end

    // Next-state logic: sequencing, pump stepping, settle timing, slot tracking.
    always_comb begin
        state_s   = state_r;
        tag_s     = tag_r;
        phase_s   = phase_r;
        k_s       = k_r;
        stroke_s  = stroke_r;
        settle_s  = settle_r;
        slot_s    = slot_r;
        full_s    = full_r;
        done_s    = 1'b0;
        aborted_s = 1'b0;
        load_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clear_slots) begin
                    slot_s = {SLOT_W{1'b0}};
                    full_s = 1'b0;
                end else if (start && !full_r) begin
                    load_s   = 1'b1;
                    tag_s    = TAG_LYSIS;
                    state_s  = entry_state(TAG_LYSIS, lysis_strokes);
                    phase_s  = {CNT_W{1'b0}};
                    k_s      = {K_W{1'b0}};
                    stroke_s = {CNT_W{1'b0}};
                    settle_s = {ST_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LYSIS, ST_WASH, ST_ELUTE: begin
                if (abort) begin
                    state_s  = ST_SETTLE;
                    tag_s    = TAG_ABORT;
                    settle_s = {ST_W{1'b0}};
                end else if (stage_last_s) begin
                    state_s  = ST_SETTLE;
                    settle_s = {ST_W{1'b0}};
                end else if (phase_last_s) begin
                    phase_s = {CNT_W{1'b0}};
                    if (k_r == K_W'(PUMP_PHASES - 1)) begin
                        k_s      = {K_W{1'b0}};
                        stroke_s = stroke_r + CNT_W'(1);
                    end else begin
                        k_s = k_r + K_W'(1);
                    end
                end else begin
                    phase_s = phase_r + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (abort && (tag_r != TAG_ABORT)) begin
                    tag_s    = TAG_ABORT;
                    settle_s = {ST_W{1'b0}};
                end else if (settle_r == ST_W'(SETTLE_CYC - 1)) begin
                    phase_s  = {CNT_W{1'b0}};
                    k_s      = {K_W{1'b0}};
                    stroke_s = {CNT_W{1'b0}};
                    settle_s = {ST_W{1'b0}};
                    case (tag_r)
                        TAG_LYSIS: begin
                            tag_s   = TAG_WASH;
                            state_s = entry_state(TAG_WASH, wsh_r);
                        end
                        TAG_WASH: begin
                            tag_s   = TAG_ELUTE;
                            state_s = entry_state(TAG_ELUTE, elu_r);
                        end
                        TAG_ELUTE: begin
                            state_s = ST_IDLE;
                            done_s  = 1'b1;
                            if (slot_r == SLOT_W'(SIZE - 1)) begin
                                slot_s = {SLOT_W{1'b0}};
                                full_s = 1'b1;
                            end else begin
                                slot_s = slot_r + SLOT_W'(1);
                            end
                        end
                        default: begin
                            state_s   = ST_IDLE;
                            aborted_s = 1'b1;
                        end
                    endcase
                end else begin
                    settle_s = settle_r + ST_W'(1);
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so every output comes straight from a flop.
    always_comb begin
        valves_s = VALVES_CLOSED;
        pump_s   = {PUMP_PHASES{1'b1}};
        sel_s    = {SIZE{1'b0}};
        case (state_s)
            ST_LYSIS: begin
                valves_s = VALVES_LYSIS;
                pump_s   = pump_pattern(k_s);
            end
            ST_WASH: begin
                valves_s = VALVES_WASH;
                pump_s   = pump_pattern(k_s);
            end
            ST_ELUTE: begin
                valves_s = VALVES_ELUTE;
                pump_s   = pump_pattern(k_s);
                sel_s    = one_hot(slot_r);
            end
            default: begin
                valves_s = VALVES_CLOSED;
            end
        endcase
    end

    // Sequencer state, counters, slot tracking and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            tag_r     <= TAG_LYSIS;
            phase_r   <= {CNT_W{1'b0}};
            k_r       <= {K_W{1'b0}};
            stroke_r  <= {CNT_W{1'b0}};
            settle_r  <= {ST_W{1'b0}};
            slot_r    <= {SLOT_W{1'b0}};
            full_r    <= 1'b0;
            valves_r  <= VALVES_CLOSED;
            pump_r    <= {PUMP_PHASES{1'b1}};
            sel_r     <= {SIZE{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            tag_r     <= tag_s;
            phase_r   <= phase_s;
            k_r       <= k_s;
            stroke_r  <= stroke_s;
            settle_r  <= settle_s;
            slot_r    <= slot_s;
            full_r    <= full_s;
            valves_r  <= valves_s;
            pump_r    <= pump_s;
            sel_r     <= sel_s;
            busy_r    <= (state_s != ST_IDLE);
            done_r    <= done_s;
            aborted_r <= aborted_s;
        end
    end

    // Run configuration is frozen at start so mid-run input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= CNT_W'(1);
            lys_r <= {CNT_W{1'b0}};
            wsh_r <= {CNT_W{1'b0}};
            elu_r <= {CNT_W{1'b0}};
        end else if (load_s) begin
            div_r <= (phase_div == {CNT_W{1'b0}}) ? CNT_W'(1) : phase_div;
            lys_r <= lysis_strokes;
            wsh_r <= wash_strokes;
            elu_r <= elute_strokes;
        end
    end

    assign {lysis_ctrl, wash_ctrl, elute_ctrl, waste_ctrl, bead_trap_ctrl, collect_ctrl} = valves_r;
    assign pump        = pump_r;
    assign collect_sel = sel_r;
    assign slot        = slot_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign aborted     = aborted_r;
    assign full        = full_r;

endmodule

// File: tb/tb_mnacidpro_seq.sv
// Bench for mnacidpro_seq: table of hand-computed runs, hand-written corner
// sequences, and random runs. All are checked cycle by cycle against a trace
// built from the stage/stroke/settle rules.
module tb_mnacidpro_seq;
    localparam int SIZE  = 6;
    localparam int P     = 3;
    localparam int CNT_W = 16;
    localparam int SW    = 2;

    logic clk = 1'b0;
    logic rst_n, start, abort, clear_slots;
    logic [CNT_W-1:0] phase_div, lysis_strokes, wash_strokes, elute_strokes;
    logic lysis_ctrl, wash_ctrl, elute_ctrl, waste_ctrl, bead_trap_ctrl, collect_ctrl;
    logic [P-1:0] pump;
    logic [SIZE-1:0] collect_sel;
    logic [2:0] slot;
    logic busy, done, aborted, full;

    mnacidpro_seq #(.SIZE(SIZE), .PUMP_PHASES(P), .CNT_W(CNT_W), .SETTLE_CYC(SW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .clear_slots(clear_slots),
        .phase_div(phase_div), .lysis_strokes(lysis_strokes), .wash_strokes(wash_strokes),
        .elute_strokes(elute_strokes), .lysis_ctrl(lysis_ctrl), .wash_ctrl(wash_ctrl),
        .elute_ctrl(elute_ctrl), .waste_ctrl(waste_ctrl), .bead_trap_ctrl(bead_trap_ctrl),
        .collect_ctrl(collect_ctrl), .pump(pump), .collect_sel(collect_sel), .slot(slot),
        .busy(busy), .done(done), .aborted(aborted), .full(full)
    );

    always #5 clk = ~clk;

    typedef logic [21:0] ovec_t;
    typedef struct {
        int div; int l; int w; int e; int ab_at; int ab_len; int exp_busy; int exp_done;
    } vec_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    m_slot   = 0;
    bit    m_full   = 1'b0;
    ovec_t tr[$];
    vec_t  vecs[7];

    function automatic ovec_t dut_vec();
        return {lysis_ctrl, wash_ctrl, elute_ctrl, waste_ctrl, bead_trap_ctrl, collect_ctrl,
                pump, collect_sel, busy, done, aborted, slot, full};
    endfunction

    // ph: 0 lysis, 1 wash, 2 elute, 3 settle, 4 idle
    function automatic ovec_t mk(int ph, int k, bit bz, bit dn, bit ab, int sl, bit fl);
        logic [5:0] v;
        logic [P-1:0] p;
        logic [SIZE-1:0] sel;
        v = 6'b111111; p = 3'b111; sel = 6'b000000;
        case (ph)
            0: begin v = 6'b011011; p[k] = 1'b0; end
            1: begin v = 6'b101011; p[k] = 1'b0; end
            2: begin v = 6'b110100; p[k] = 1'b0; sel[sl] = 1'b1; end
            default: v = 6'b111111;
        endcase
        return {v, p, sel, bz, dn, ab, 3'(sl), fl};
    endfunction

    task automatic check(string name, ovec_t act, ovec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected busy-cycle trace from the stage rules; abort truncates and appends a settle window.
    task automatic build(int div, int l, int w, int e, int ab_at, output bit abd);
        int d;
        int st[3];
        tr.delete();
        d = (div == 0) ? 1 : div;
        st[0] = l; st[1] = w; st[2] = e;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < st[s] * P * d; i++) tr.push_back(mk(s, (i / d) % P, 1, 0, 0, m_slot, m_full));
            for (int j = 0; j < SW; j++) tr.push_back(mk(3, 0, 1, 0, 0, m_slot, m_full));
        end
        abd = (ab_at >= 0) && (ab_at < tr.size());
        if (abd) begin
            while (tr.size() > ab_at + 1) void'(tr.pop_back());
            for (int j = 0; j < SW; j++) tr.push_back(mk(3, 0, 1, 0, 0, m_slot, m_full));
        end
    endtask

    task automatic run_one(string tag, int div, int l, int w, int e, int ab_at, int ab_len,
                           output int busy_cnt, output int got_done);
        bit abd;
        build(div, l, w, e, ab_at, abd);
        phase_div = 16'(div); lysis_strokes = 16'(l); wash_strokes = 16'(w); elute_strokes = 16'(e);
        start = 1'b1;
        step();
        start = 1'b0;
        phase_div = 16'($urandom); lysis_strokes = 16'($urandom);
        wash_strokes = 16'($urandom); elute_strokes = 16'($urandom);
        busy_cnt = 0;
        for (int c = 0; c < tr.size(); c++) begin
            check($sformatf("%s_cyc%0d", tag, c), dut_vec(), tr[c]);
            if (busy) busy_cnt++;
            abort = (ab_at >= 0) && (c >= ab_at) && (c < ab_at + ab_len);
            step();
        end
        if (!abd) begin
            m_slot++;
            if (m_slot == SIZE) begin m_slot = 0; m_full = 1'b1; end
        end
        got_done = int'(done);
        check($sformatf("%s_end", tag), dut_vec(), mk(4, 0, 0, !abd, abd, m_slot, m_full));
        abort = 1'b0;
        step();
        check($sformatf("%s_quiet", tag), dut_vec(), mk(4, 0, 0, 0, 0, m_slot, m_full));
    endtask

    task automatic try_idle(string tag, bit st, bit clr);
        start = st; clear_slots = clr;
        step();
        start = 1'b0; clear_slots = 1'b0;
        if (clr) begin m_slot = 0; m_full = 1'b0; end
        check(tag, dut_vec(), mk(4, 0, 0, 0, 0, m_slot, m_full));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, gd, ab_at;
        vecs[0] = '{2, 1, 1, 1, -1, 0, 24, 1};
        vecs[1] = '{0, 1, 0, 1, -1, 0, 12, 1};
        vecs[2] = '{1, 0, 0, 0, -1, 0, 6, 1};
        vecs[3] = '{3, 2, 1, 0, -1, 0, 33, 1};
        vecs[4] = '{2, 1, 1, 1, 10, 1, 13, 0};
        vecs[5] = '{1, 1, 1, 1, 2, 3, 5, 0};
        vecs[6] = '{1, 1, 1, 1, 14, 1, 17, 0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; clear_slots = 1'b0;
        phase_div = '0; lysis_strokes = '0; wash_strokes = '0; elute_strokes = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        check("reset_state", dut_vec(), mk(4, 0, 0, 0, 0, 0, 0));
        step();
        try_idle("abort_in_idle", 1'b0, 1'b0);

        // Hand-computed table of runs.
        for (int v = 0; v < 7; v++) begin
            run_one($sformatf("vec%0d", v), vecs[v].div, vecs[v].l, vecs[v].w, vecs[v].e,
                    vecs[v].ab_at, vecs[v].ab_len, bc, gd);
            check_int($sformatf("vec%0d_busy_cycles", v), bc, vecs[v].exp_busy);
            check_int($sformatf("vec%0d_done", v), gd, vecs[v].exp_done);
        end
        check_int("slot_after_table", int'(slot), 4);

        // Slot walk until full, then full/clear handling.
        try_idle("clear_slots", 1'b0, 1'b1);
        for (int r = 0; r < SIZE; r++) run_one($sformatf("walk%0d", r), 1, 1, 1, 1, -1, 0, bc, gd);
        check_int("full_after_six", int'({full, slot}), 8);
        try_idle("start_when_full", 1'b1, 1'b0);
        try_idle("clear_beats_start", 1'b1, 1'b1);
        check_int("cleared_slot_full", int'({full, slot}), 0);
        run_one("after_clear", 2, 1, 1, 1, -1, 0, bc, gd);

        // Random runs with optional aborts and slot clears.
        for (int r = 0; r < 30; r++) begin
            if (m_full && ($urandom_range(0, 1) == 0)) try_idle($sformatf("rnd%0d_full", r), 1'b1, 1'b0);
            if ($urandom_range(0, 7) == 0) try_idle($sformatf("rnd%0d_clr", r), 1'b0, 1'b1);
            if (m_full) try_idle($sformatf("rnd%0d_clr2", r), 1'b1, 1'b1);
            ab_at = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, 40)) : -1;
            run_one($sformatf("rnd%0d", r), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), ab_at,
                    int'($urandom_range(1, 3)), bc, gd);
        end

        // Asynchronous reset in the middle of ELUTE.
        if (m_full) try_idle("pre_reset_clr", 1'b0, 1'b1);
        begin
            bit abd;
            build(2, 1, 1, 1, -1, abd);
            phase_div = 16'd2; lysis_strokes = 16'd1; wash_strokes = 16'd1; elute_strokes = 16'd1;
            start = 1'b1;
            step();
            start = 1'b0;
            repeat (18) step();
            check("mid_elute", dut_vec(), tr[18]);
            #3 rst_n = 1'b0;
            #1;
            m_slot = 0; m_full = 1'b0;
            check("async_reset", dut_vec(), mk(4, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
            rst_n = 1'b1;
            step();
            check("after_reset", dut_vec(), mk(4, 0, 0, 0, 0, 0, 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mnacidpro_seq.md
Name: mnacidpro_seq

Overview:
- Parametrised on-chip sequencer for the nucleic-acid purification fluidics: N-phase peristaltic pump plus lysis/wash/elute/waste/bead-trap/collect valves.
- Runs one sample per start through the LYSIS → WASH → ELUTE sequence.
- Routes each eluate to the next of SIZE collect outlets; tracks slot occupancy.
- Sits between the host/pad controller and the ctrl pads of the mnacidpro_pads fluidic netlist. All valve outputs: 1 = pressurised/closed.

Parameters:
- SIZE, 6, number of collect outlets (>=1).
- PUMP_PHASES, 3, peristaltic pump valves (>=3).
- CNT_W, 16, width of stroke counts and phase_div.
- SETTLE_CYC, 2, all-closed cycles inserted after every stage (>=1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin one sample run; sampled only in IDLE.
- abort  input  1  terminate the current run.
- clear_slots  input  1  reset the slot pointer and the full flag; honoured only in IDLE.
- phase_div  input  CNT_W  cycles per pump phase; 0 is treated as 1; captured at start.
- lysis_strokes  input  CNT_W  pump strokes in LYSIS; captured at start.
- wash_strokes  input  CNT_W  pump strokes in WASH; captured at start.
- elute_strokes  input  CNT_W  pump strokes in ELUTE; captured at start.
- lysis_ctrl  output  1  lysis inlet valve.
- wash_ctrl  output  1  wash inlet valve.
- elute_ctrl  output  1  elute inlet valve.
- waste_ctrl  output  1  waste outlet valve.
- bead_trap_ctrl  output  1  bead trap valve (1 = trap engaged).
- collect_ctrl  output  1  collect manifold valve.
- pump  output  PUMP_PHASES  pump valve drive.
- collect_sel  output  SIZE  one-hot collect outlet select (1 = open).
- slot  output  $clog2(SIZE) (min 1)  next outlet index.
- busy  output  1  high while not IDLE.
- done  output  1  one-cycle pulse when a run completes.
- aborted  output  1  one-cycle pulse when an aborted run reaches IDLE.
- full  output  1  all SIZE slots used.

Behaviour:
- All outputs are registered.
- Reset values:
  - every *_ctrl = 1 and pump = all 1s.
  - collect_sel = 0, slot = 0.
  - busy, done, aborted, full = 0.
  - state = IDLE.
- Reset mid-run returns to these values immediately (asynchronous).
- States: IDLE, LYSIS, WASH, ELUTE, SETTLE. A 2-bit stage register records which stage SETTLE follows.
- IDLE:
  - All valves closed.
  - start && !full: capture config; next cycle enter LYSIS; busy = 1 from that cycle.
  - start && full: ignored.
  - clear_slots: slot ← 0, full ← 0. If start and clear_slots coincide, clear_slots wins and start is ignored.
- Pump stepping:
  - Phase counter counts 0..D-1, where D = max(phase_div, 1).
  - Phase index k counts 0..PUMP_PHASES-1; pump = all 1s except bit k = 0.
  - One stroke = PUMP_PHASES phases. A stage lasts strokes·PUMP_PHASES·D cycles.
  - k and the phase counter reset to 0 on every stage entry.
- Stage valves (ctrl = 0 means open; all others 1; collect_sel = 0 unless stated):
  - LYSIS: lysis_ctrl = 0, waste_ctrl = 0, bead_trap_ctrl = 1.
  - WASH: wash_ctrl = 0, waste_ctrl = 0, bead_trap_ctrl = 1.
  - ELUTE: elute_ctrl = 0, collect_ctrl = 0, bead_trap_ctrl = 0, collect_sel = one-hot(slot).
- Zero strokes: the stage occupies 0 cycles; the FSM goes directly to the SETTLE that follows it.
- SETTLE (break-before-make):
  - All valves closed, pump all 1s, for exactly SETTLE_CYC cycles.
  - Then: after LYSIS → WASH; after WASH → ELUTE; after ELUTE → IDLE.
- Completion (SETTLE after ELUTE → IDLE):
  - done = 1 for the first IDLE cycle.
  - slot increments; if slot was SIZE-1, slot ← 0 and full ← 1.
- abort (any non-IDLE state, including SETTLE):
  - Next cycle enter SETTLE, stage tagged ABORT; after SETTLE_CYC cycles → IDLE with aborted = 1 for one cycle.
  - No slot change, no done.
  - abort in IDLE has no effect. abort during an abort-SETTLE has no effect (the count is not restarted).
- start and abort asserted outside IDLE: start is ignored.
- Config inputs changing mid-run have no effect.

Test Plan:
- Default params, phase_div = 2, strokes 1/1/1, start at cycle 0 → busy high 24 cycles (6 LYSIS, 2 settle, 6 WASH, 2, 6 ELUTE, 2); pump pattern 110,110,101,101,011,011 each stage; done on cycle 25; slot = 1.
- Same config, check valves per stage: LYSIS lysis = waste = 0; ELUTE collect_sel = 000001, elute = collect = bead_trap = 0; SETTLE cycles all ctrl = 1, pump = 111.
- Six back-to-back runs → collect_sel walks 000001..100000; after the sixth run full = 1, slot = 0; seventh start ignored (busy stays 0); clear_slots then start → run proceeds, collect_sel = 000001.
- wash_strokes = 0, phase_div = 0 → WASH skipped (LYSIS, SETTLE, SETTLE, ELUTE); phase_div treated as 1 (each pump phase lasts 1 cycle).
- abort on the 3rd WASH cycle → all valves closed for 2 cycles, then aborted pulse, done = 0, slot unchanged.
- Assert rst_n low mid-ELUTE → all ctrl = 1, collect_sel = 0, slot = 0, busy = 0 asynchronously (before the next clk edge).
